// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM-stage load/store unit of the 5-stage RV32I pipeline.
//
// Runs a request/grant/response handshake with data memory for loads and
// stores in the MEM stage. It holds the pipeline stalled while an access is
// outstanding. Load data is formatted (byte/half select, sign/zero extension)
// into M_ld_data for the MEM/WB register.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   M_mem_re/we      load/store in MEM stage
//   M_funct3         access type (B/H/W/BU/HU)
//   M_alu_out        effective byte address
//   M_rs2_data       store data
//   M_ld_data        formatted load data (holds between loads)
//   lsu_stall        freeze PC/IF/ID/EX/MEM registers
//   dmem_*           data memory request/response interface
//   misalign_exc     only with LSU_MISALIGN_TRAP_EN: misaligned H/W access
//
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses raise misalign_exc instead of going to memory.
//
// state | meaning
// IDLE  | no access outstanding; captures a new access
// REQ   | dmem_req high, request held stable until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// DONE  | stall released for one cycle so the pipeline advances
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  M_mem_re,
  input  logic                  M_mem_we,
  input  logic [2:0]            M_funct3,
  input  logic [31:0]           M_alu_out,
  input  logic [31:0]           M_rs2_data,
  output logic [31:0]           M_ld_data,
  output logic                  lsu_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_wstrb,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  misalign_exc,
`endif
  input  logic [31:0]           dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [31:0]           ld_data_q, ld_fmt;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  legal_f3;
  logic                  access;
  logic                  start;

  always_comb begin
    case (M_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
      default:                                 legal_f3 = 1'b0;
    endcase
  end

  assign access = (M_mem_re | M_mem_we) & legal_f3;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  // funct3[1:0] = 01 covers H and HU; 10 is W (the only legal 1x encoding)
  assign misalign = access &
                    (((M_funct3[1:0] == 2'b01) & M_alu_out[0]) |
                     ((M_funct3[1:0] == 2'b10) & (|M_alu_out[1:0])));
  assign start        = access & ~misalign;
  assign misalign_exc = (state_q == IDLE) & misalign;
`else
  assign start = access;
`endif

  // Store lane steering; offset bits below the access size are ignored.
  always_comb begin
    case (M_funct3[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << M_alu_out[1:0];
        wdata_d = {4{M_rs2_data[7:0]}};
      end
      2'b01: begin
        wstrb_d = M_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{M_rs2_data[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = M_rs2_data;
      end
    endcase
  end

  always_comb begin
    case (off_q)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_fmt = {24'h0, byte_sel};
      3'b101:  ld_fmt = {16'h0, half_sel};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)       state_d = REQ;
      REQ:  if (dmem_gnt)    state_d = we_q ? DONE : WAIT;
      WAIT: if (dmem_rvalid) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = (state_q == REQ);
    lsu_stall = ((state_q == IDLE) & start) | (state_q == REQ) | (state_q == WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= 4'h0;
      wdata_q   <= 32'h0;
      funct3_q  <= 3'h0;
      off_q     <= 2'h0;
      ld_data_q <= 32'h0;
    end else begin
      if ((state_q == IDLE) && start) begin
        addr_q   <= M_alu_out[ADDR_WIDTH+1:2];
        we_q     <= M_mem_we;
        wstrb_q  <= wstrb_d;
        wdata_q  <= wdata_d;
        funct3_q <= M_funct3;
        off_q    <= M_alu_out[1:0];
      end
      if ((state_q == WAIT) && dmem_rvalid) ld_data_q <= ld_fmt;
    end
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdata_q;
  assign M_ld_data  = ld_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_mem_re = 1'b0;
  logic        M_mem_we = 1'b0;
  logic [2:0]  M_funct3 = 3'h0;
  logic [31:0] M_alu_out = 32'h0;
  logic [31:0] M_rs2_data = 32'h0;
  logic [31:0] M_ld_data;
  logic        lsu_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [13:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_WIDTH(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .M_mem_re    (M_mem_re),
    .M_mem_we    (M_mem_we),
    .M_funct3    (M_funct3),
    .M_alu_out   (M_alu_out),
    .M_rs2_data  (M_rs2_data),
    .M_ld_data   (M_ld_data),
    .lsu_stall   (lsu_stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_exc(misalign_exc),
`endif
    .dmem_rdata  (dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    M_mem_re = 1'b0; M_mem_we = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check("idle_stall", lsu_stall, 0);
    check("idle_req", dmem_req, 0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int gnt_dly,
                         input int rv_wait, input bit rv_in_req,
                         input logic [31:0] exp_addr, input logic [31:0] exp_ld);
    int stalls = 0;
    @(posedge clk); #1;
    M_mem_re = 1'b1; M_mem_we = 1'b0; M_funct3 = f3; M_alu_out = addr;
    M_rs2_data = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #1;
    check("ld_idle_req", dmem_req, 0);
    if (lsu_stall) stalls++;
    for (int i = 0; i <= gnt_dly; i++) begin
      @(posedge clk); #1;
      dmem_rvalid = rv_in_req; dmem_rdata = 32'hDEAD_DEAD;
      dmem_gnt = (i == gnt_dly);
      #1;
      check("ld_req", dmem_req, 1);
      check("ld_addr", dmem_addr, exp_addr);
      check("ld_we", dmem_we, 0);
      if (lsu_stall) stalls++;
    end
    for (int i = 0; i <= rv_wait; i++) begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = (i == rv_wait);
      dmem_rdata = (i == rv_wait) ? rdata : 32'h0;
      #1;
      check("ld_wait_req", dmem_req, 0);
      if (lsu_stall) stalls++;
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    #1;
    check("ld_done_stall", lsu_stall, 0);
    check("ld_done_req", dmem_req, 0);
    check("ld_data", M_ld_data, exp_ld);
    check("ld_stall_cycles", stalls, 3 + gnt_dly + rv_wait);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int gnt_dly,
                          input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    int stalls = 0;
    @(posedge clk); #1;
    M_mem_re = 1'b0; M_mem_we = 1'b1; M_funct3 = f3; M_alu_out = addr;
    M_rs2_data = rs2; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check("st_idle_req", dmem_req, 0);
    if (lsu_stall) stalls++;
    for (int i = 0; i <= gnt_dly; i++) begin
      @(posedge clk); #1;
      dmem_gnt = (i == gnt_dly);
      #1;
      check("st_req", dmem_req, 1);
      check("st_we", dmem_we, 1);
      check("st_addr", dmem_addr, exp_addr);
      check("st_wstrb", dmem_wstrb, exp_wstrb);
      check("st_wdata", dmem_wdata, exp_wdata);
      if (lsu_stall) stalls++;
    end
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1;
    check("st_done_stall", lsu_stall, 0);
    check("st_done_req", dmem_req, 0);
    check("st_ld_hold", M_ld_data, exp_ld);
    check("st_stall_cycles", stalls, 2 + gnt_dly);
  endtask

  initial begin
    #2;
    check("rst_req", dmem_req, 0);
    check("rst_stall", lsu_stall, 0);
    check("rst_ld", M_ld_data, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_we", dmem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    // LB / LBU at byte offset 3
    do_load(3'b000, 32'h103, 32'h80FF_1234, 0, 0, 0, 32'h40, 32'hFFFF_FF80);
    do_load(3'b100, 32'h103, 32'h80FF_1234, 0, 0, 0, 32'h40, 32'h0000_0080);

    // reset while a load sits in WAIT
    @(posedge clk); #1;
    M_mem_re = 1'b1; M_mem_we = 1'b0; M_funct3 = 3'b010; M_alu_out = 32'h40;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1;
    check("wait_stall_pre", lsu_stall, 1);
    #2;
    rst = 1'b1; M_mem_re = 1'b0;
    #1;
    check("midrst_req", dmem_req, 0);
    check("midrst_ld", M_ld_data, 0);
    check("midrst_stall", lsu_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    check("postrst_stall", lsu_stall, 0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    #1;
    check("postrst_ld", M_ld_data, 0);
    check("postrst_req", dmem_req, 0);

    // SH with delayed grant
    do_store(3'b001, 32'h202, 32'hDEAD_BEEF, 3, 32'h80, 4'b1100, 32'hBEEF_BEEF, 32'h0);

    // LW with slow rvalid and spurious rvalid during REQ, then SW
    do_load(3'b010, 32'h10, 32'h1234_5678, 1, 3, 1, 32'h4, 32'h1234_5678);
    do_store(3'b010, 32'h20, 32'hCAFE_F00D, 0, 32'h8, 4'b1111, 32'hCAFE_F00D, 32'h1234_5678);

    // back-to-back LH then SB
    do_load(3'b001, 32'h2, 32'h8001_7FFF, 0, 0, 0, 32'h0, 32'hFFFF_8001);
    do_store(3'b000, 32'h1, 32'h0000_00A5, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001);

    do_load(3'b101, 32'h2, 32'h8001_7FFF, 0, 0, 0, 32'h0, 32'h0000_8001);
    do_load(3'b001, 32'h0, 32'h1234_F00F, 2, 1, 0, 32'h0, 32'hFFFF_F00F);
    do_load(3'b000, 32'h4, 32'h0000_007F, 0, 0, 0, 32'h1, 32'h0000_007F);

`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    M_mem_re = 1'b1; M_mem_we = 1'b0; M_funct3 = 3'b010; M_alu_out = 32'h6;
    #1;
    check("trap_exc", misalign_exc, 1);
    check("trap_stall", lsu_stall, 0);
    check("trap_req", dmem_req, 0);
    @(posedge clk); #1;
    M_mem_re = 1'b0;
    #1;
    check("trap_exc_clr", misalign_exc, 0);
    check("trap_req_after", dmem_req, 0);
    check("trap_ld_hold", M_ld_data, 32'h0000_007F);
`else
    // misaligned accesses fall back to the aligned word / low lanes
    do_load(3'b010, 32'h6, 32'h1122_3344, 0, 0, 0, 32'h1, 32'h1122_3344);
    do_store(3'b001, 32'h201, 32'h0000_1357, 0, 32'h80, 4'b0011, 32'h1357_1357, 32'h1122_3344);
`endif

    // illegal funct3: no access, no stall
    @(posedge clk); #1;
    M_mem_re = 1'b1; M_mem_we = 1'b0; M_funct3 = 3'b011; M_alu_out = 32'h0;
    #1;
    check("illegal_stall", lsu_stall, 0);
    @(posedge clk); #1;
    check("illegal_req", dmem_req, 0);
    check("illegal_stall2", lsu_stall, 0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
